// File: rtl/mp_csa_resolver_if.sv
// Bus bundle for the carry-save accumulator / carry-resolution engine.
// The master drives the accumulate and resolve requests; the slave (the engine) reports
// its status and exposes the accumulator contents.
interface mp_csa_resolver_if #(
    parameter int WIDTH = 514
);
    logic             clear;
    logic             acc_en;
    logic             acc_shift;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_m;
    logic             start;
    logic             reduce;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [1:0]       q_bits;
    logic             cout;

    modport master (
        output clear, acc_en, acc_shift, in_a, in_m, start, reduce,
        input  busy, done, result, q_bits, cout
    );

    modport slave (
        input  clear, acc_en, acc_shift, in_a, in_m, start, reduce,
        output busy, done, result, q_bits, cout
    );
endinterface

// File: rtl/mp_csa_resolver.sv
// Multi-precision carry-save accumulator with a limb-serial carry-resolution engine.
// The running sum is kept as (S, C) so that accumulation is single-cycle at any width.
// On start, S+C is collapsed into binary one LIMB-bit limb per cycle, and when reduce is
// set the engine then computes R-M limb by limb into C and keeps it only if R >= M.
module mp_csa_resolver #(
    parameter int WIDTH = 514,
    parameter int LIMB  = 103
) (
    input logic              clk,
    input logic              resetn,
    mp_csa_resolver_if.slave bus
);

    localparam int NL   = (WIDTH + LIMB - 1) / LIMB;
    localparam int TOPW = WIDTH - (NL - 1) * LIMB;
    localparam int KW   = (NL > 1) ? $clog2(NL) : 1;
    localparam int PW   = NL * LIMB;

    localparam logic [KW-1:0]   KLAST     = KW'(NL - 1);
    localparam logic [LIMB-1:0] LIMB_ONES = '1;
    localparam logic [LIMB-1:0] TOP_MASK  = LIMB_ONES >> (LIMB - TOPW);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ADD    = 3'd1;
    localparam logic [2:0] ST_SUB    = 3'd2;
    localparam logic [2:0] ST_COMMIT = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    logic [2:0]       state;
    logic [WIDTH-1:0] s_reg;
    logic [WIDTH-1:0] c_reg;
    logic [KW-1:0]    k;
    logic             cy;
    logic             reduce_q;
    logic             cout_q;

    logic [WIDTH-1:0] csa_s;
    logic [WIDTH-1:0] csa_c;

    int               base;
    logic             last_limb;
    logic [LIMB-1:0]  s_limb;
    logic [LIMB-1:0]  c_limb;
    logic [LIMB-1:0]  m_limb;
    logic [LIMB-1:0]  op_b;
    logic [LIMB:0]    lsum;
    logic             carry;
    logic [WIDTH-1:0] wmask;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] s_upd;
    logic [WIDTH-1:0] c_upd;

    // Full-adder row: new sum bits and majority carries moved up one position.
    always_comb begin
        csa_s = s_reg ^ c_reg ^ bus.in_a;
        csa_c = ((s_reg & c_reg) | (s_reg & bus.in_a) | (c_reg & bus.in_a)) << 1;
    end

    // One limb of carry propagation: S_k + C_k + cy during ADD, S_k + ~M_k + cy during SUB.
    // The top limb may be narrower than LIMB, so its carry is taken at bit TOPW and the
    // inverted modulus is masked to the real limb width.
    always_comb begin
        base      = int'(k) * LIMB;
        last_limb = (k == KLAST);
        s_limb    = LIMB'(s_reg >> base);
        c_limb    = LIMB'(c_reg >> base);
        m_limb    = LIMB'(bus.in_m >> base);
        op_b      = c_limb;
        if (state == ST_SUB) begin
            op_b = ~m_limb & (last_limb ? TOP_MASK : LIMB_ONES);
        end
        lsum      = {1'b0, s_limb} + {1'b0, op_b} + (LIMB + 1)'(cy);
        carry     = last_limb ? lsum[TOPW] : lsum[LIMB];
        wmask     = WIDTH'(PW'(LIMB_ONES) << base);
        wdata     = WIDTH'(PW'(lsum[LIMB-1:0]) << base);
        s_upd     = (s_reg & ~wmask) | (wdata & wmask);
        c_upd     = (c_reg & ~wmask) | (wdata & wmask);
    end

    // Accumulator registers and the resolve/reduce sequencer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            s_reg    <= '0;
            c_reg    <= '0;
            k        <= '0;
            cy       <= 1'b0;
            reduce_q <= 1'b0;
            cout_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.clear) begin
                        s_reg <= '0;
                        c_reg <= '0;
                    end else if (bus.acc_en) begin
                        if (bus.acc_shift) begin
                            s_reg <= csa_s >> 1;
                            c_reg <= csa_c >> 1;
                        end else begin
                            s_reg <= csa_s;
                            c_reg <= csa_c;
                        end
                    end else if (bus.start) begin
                        state    <= ST_ADD;
                        reduce_q <= bus.reduce;
                        k        <= '0;
                        cy       <= 1'b0;
                        cout_q   <= 1'b0;
                    end
                end
                ST_ADD: begin
                    s_reg <= s_upd;
                    cy    <= carry;
                    if (last_limb) begin
                        cout_q <= carry;
                        c_reg  <= '0;
                        k      <= '0;
                        if (reduce_q) begin
                            state <= ST_SUB;
                            cy    <= 1'b1;
                        end else begin
                            state <= ST_DONE;
                        end
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                ST_SUB: begin
                    c_reg <= c_upd;
                    cy    <= carry;
                    if (last_limb) begin
                        state <= ST_COMMIT;
                        k     <= '0;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                ST_COMMIT: begin
                    if (cy) begin
                        s_reg <= c_reg;
                    end
                    c_reg <= '0;
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = (state == ST_ADD) || (state == ST_SUB) || (state == ST_COMMIT);
    assign bus.done   = (state == ST_DONE);
    assign bus.result = s_reg;
    assign bus.q_bits = s_reg[1:0] + c_reg[1:0];
    assign bus.cout   = cout_q;

endmodule

// File: tb/tb_mp_csa_resolver.sv
// Directed bench for mp_csa_resolver: a 514/103 instance and a 64/16 instance share the
// same stimulus (the small one sees the low 64 bits) and are checked against hand values.
module tb_mp_csa_resolver;

    localparam int W  = 514;
    localparam int L  = 103;
    localparam int W2 = 64;
    localparam int L2 = 16;

    logic clk;
    logic resetn;
    int   tests_run;
    int   tests_failed;

    mp_csa_resolver_if #(.WIDTH(W))  bus ();
    mp_csa_resolver_if #(.WIDTH(W2)) bus2 ();

    assign bus2.clear     = bus.clear;
    assign bus2.acc_en    = bus.acc_en;
    assign bus2.acc_shift = bus.acc_shift;
    assign bus2.start     = bus.start;
    assign bus2.reduce    = bus.reduce;
    assign bus2.in_a      = bus.in_a[W2-1:0];
    assign bus2.in_m      = bus.in_m[W2-1:0];

    mp_csa_resolver #(.WIDTH(W), .LIMB(L)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    mp_csa_resolver #(.WIDTH(W2), .LIMB(L2)) dut2 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a wait escapes its cycle bound.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic do_clear();
        @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
    endtask

    task automatic do_acc(input logic [W-1:0] v, input logic sh);
        @(negedge clk);
        bus.acc_en    = 1'b1;
        bus.acc_shift = sh;
        bus.in_a      = v;
        @(negedge clk);
        bus.acc_en    = 1'b0;
        bus.acc_shift = 1'b0;
        bus.in_a      = '0;
    endtask

    // Pulses start and reports the cycle (counted from the start edge) in which each
    // instance shows done, plus the number of cycles the large instance was busy.
    task automatic run_resolve(input logic r, output int lat_b, output int lat_s,
                               output int busy_b);
        lat_b  = 0;
        lat_s  = 0;
        busy_b = 0;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.reduce = r;
        for (int n = 1; n <= 40 && lat_b == 0; n++) begin
            @(negedge clk);
            bus.start  = 1'b0;
            bus.reduce = 1'b0;
            if (bus.busy) busy_b++;
            if (bus.done && lat_b == 0) lat_b = n;
            if (bus2.done && lat_s == 0) lat_s = n;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests_run++;
        if (bus.busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_busy: got %0b expected 0", bus.busy);
        end
        tests_run++;
        if (bus.done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_done: got %0b expected 0", bus.done);
        end
        tests_run++;
        if (bus.result !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_result: got %0h expected 0", bus.result);
        end
        tests_run++;
        if (bus.q_bits !== 2'd0 || bus.cout !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_qbits_cout: got %0d/%0b expected 0/0", bus.q_bits, bus.cout);
        end
        tests_run++;
        if (bus2.result !== '0 || bus2.busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_small: got %0h/%0b expected 0/0", bus2.result, bus2.busy);
        end
        resetn = 1'b1;
    endtask

    task automatic test_accumulate();
        int lb, ls, bb;
        do_clear();
        for (int i = 0; i < 3; i++) do_acc(W'(5), 1'b0);
        run_resolve(1'b0, lb, ls, bb);
        tests_run++;
        if (lb != 6 || ls != 5) begin
            tests_failed++;
            $display("[TB] FAIL acc_latency: got %0d/%0d expected 6/5", lb, ls);
        end
        tests_run++;
        if (bb != 5) begin
            tests_failed++;
            $display("[TB] FAIL acc_busy_cycles: got %0d expected 5", bb);
        end
        tests_run++;
        if (bus.result !== W'(15) || bus2.result !== W2'(15)) begin
            tests_failed++;
            $display("[TB] FAIL acc_result: got %0h/%0h expected f/f", bus.result, bus2.result);
        end
        tests_run++;
        if (dut.c_reg !== '0 || dut2.c_reg !== '0) begin
            tests_failed++;
            $display("[TB] FAIL acc_c_zero: got %0h/%0h expected 0/0", dut.c_reg, dut2.c_reg);
        end
        tests_run++;
        if (bus.cout !== 1'b0 || bus2.cout !== 1'b0 || bus.q_bits !== 2'd3) begin
            tests_failed++;
            $display("[TB] FAIL acc_cout_qbits: got %0b/%0b/%0d expected 0/0/3", bus.cout, bus2.cout, bus.q_bits);
        end
    endtask

    task automatic test_shift();
        int lb, ls, bb;
        do_clear();
        do_acc(W'(6), 1'b1);
        tests_run++;
        if (bus.result !== W'(3)) begin
            tests_failed++;
            $display("[TB] FAIL shift_s: got %0h expected 3", bus.result);
        end
        run_resolve(1'b0, lb, ls, bb);
        tests_run++;
        if (bus.result !== W'(3) || bus2.result !== W2'(3)) begin
            tests_failed++;
            $display("[TB] FAIL shift_result: got %0h/%0h expected 3/3", bus.result, bus2.result);
        end
        do_clear();
        do_acc(W'(3), 1'b0);
        tests_run++;
        if (bus.q_bits !== 2'd3) begin
            tests_failed++;
            $display("[TB] FAIL qbits_after_3: got %0d expected 3", bus.q_bits);
        end
        do_acc(W'(1), 1'b0);
        tests_run++;
        if (bus.q_bits !== 2'd0 || bus2.q_bits !== 2'd0) begin
            tests_failed++;
            $display("[TB] FAIL qbits_after_3_1: got %0d/%0d expected 0/0", bus.q_bits, bus2.q_bits);
        end
        run_resolve(1'b0, lb, ls, bb);
        tests_run++;
        if (bus.result !== W'(4) || bus2.result !== W2'(4)) begin
            tests_failed++;
            $display("[TB] FAIL qbits_resolve: got %0h/%0h expected 4/4", bus.result, bus2.result);
        end
    endtask

    task automatic test_limb_boundary();
        logic [W-1:0]  va [3];
        logic [W-1:0]  vb [3];
        logic [W-1:0]  eb [3];
        logic [W2-1:0] es [3];
        logic          cb [3];
        logic          cs [3];
        int lb, ls, bb;
        va[0] = '0; va[0][102:0] = '1; vb[0] = W'(1);
        eb[0] = '0; eb[0][103] = 1'b1;  cb[0] = 1'b0; es[0] = '0;          cs[0] = 1'b1;
        va[1] = '1; vb[1] = W'(1);
        eb[1] = '0;                     cb[1] = 1'b1; es[1] = '0;          cs[1] = 1'b1;
        va[2] = W'(65535); vb[2] = W'(1);
        eb[2] = W'(65536);              cb[2] = 1'b0; es[2] = W2'(65536);  cs[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_clear();
            do_acc(va[i], 1'b0);
            do_acc(vb[i], 1'b0);
            run_resolve(1'b0, lb, ls, bb);
            tests_run++;
            if (bus.result !== eb[i] || bus.cout !== cb[i]) begin
                tests_failed++;
                $display("[TB] FAIL limb_big[%0d]: got %0h cout %0b expected %0h cout %0b", i, bus.result, bus.cout, eb[i], cb[i]);
            end
            tests_run++;
            if (bus2.result !== es[i] || bus2.cout !== cs[i]) begin
                tests_failed++;
                $display("[TB] FAIL limb_small[%0d]: got %0h cout %0b expected %0h cout %0b", i, bus2.result, bus2.cout, es[i], cs[i]);
            end
            tests_run++;
            if (lb != 6 || ls != 5) begin
                tests_failed++;
                $display("[TB] FAIL limb_latency[%0d]: got %0d/%0d expected 6/5", i, lb, ls);
            end
        end
    endtask

    task automatic test_reduce();
        int vals [3];
        int exps [3];
        int lb, ls, bb;
        vals[0] = 1234; exps[0] = 234;
        vals[1] = 999;  exps[1] = 999;
        vals[2] = 1000; exps[2] = 0;
        bus.in_m = W'(1000);
        for (int i = 0; i < 3; i++) begin
            do_clear();
            do_acc(W'(vals[i]), 1'b0);
            run_resolve(1'b1, lb, ls, bb);
            tests_run++;
            if (bus.result !== W'(exps[i]) || bus2.result !== W2'(exps[i])) begin
                tests_failed++;
                $display("[TB] FAIL reduce_result[%0d]: got %0d/%0d expected %0d", i, bus.result, bus2.result, exps[i]);
            end
            tests_run++;
            if (lb != 12 || ls != 10) begin
                tests_failed++;
                $display("[TB] FAIL reduce_latency[%0d]: got %0d/%0d expected 12/10", i, lb, ls);
            end
            tests_run++;
            if (bb != 11 || dut.c_reg !== '0) begin
                tests_failed++;
                $display("[TB] FAIL reduce_busy_c[%0d]: got %0d/%0h expected 11/0", i, bb, dut.c_reg);
            end
        end
        bus.in_m = '0;
    endtask

    task automatic test_protocol();
        int lb;
        do_clear();
        do_acc(W'(7), 1'b0);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.reduce = 1'b0;
        @(negedge clk);
        bus.start  = 1'b0;
        tests_run++;
        if (bus.busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL proto_busy: got %0b expected 1", bus.busy);
        end
        bus.acc_en = 1'b1;
        bus.in_a   = W'(100);
        bus.start  = 1'b1;
        @(negedge clk);
        bus.acc_en = 1'b0;
        bus.in_a   = '0;
        bus.start  = 1'b0;
        lb = 0;
        for (int n = 3; n <= 40 && lb == 0; n++) begin
            @(negedge clk);
            if (bus.done) lb = n;
        end
        tests_run++;
        if (lb != 6) begin
            tests_failed++;
            $display("[TB] FAIL proto_latency: got %0d expected 6", lb);
        end
        tests_run++;
        if (bus.result !== W'(7) || bus2.result !== W2'(7)) begin
            tests_failed++;
            $display("[TB] FAIL proto_result: got %0h/%0h expected 7/7", bus.result, bus2.result);
        end
        @(negedge clk);
        tests_run++;
        if (bus.busy !== 1'b0 || bus.result !== W'(7)) begin
            tests_failed++;
            $display("[TB] FAIL proto_no_restart: got busy %0b result %0h expected 0/7", bus.busy, bus.result);
        end
        do_acc(W'(9), 1'b0);
        @(negedge clk);
        bus.clear  = 1'b1;
        bus.acc_en = 1'b1;
        bus.in_a   = W'(5);
        @(negedge clk);
        bus.clear  = 1'b0;
        bus.acc_en = 1'b0;
        bus.in_a   = '0;
        tests_run++;
        if (bus.result !== '0 || dut.c_reg !== '0 || bus.q_bits !== 2'd0) begin
            tests_failed++;
            $display("[TB] FAIL proto_clear_wins: got S %0h C %0h expected 0/0", bus.result, dut.c_reg);
        end
    endtask

    task automatic test_reset_mid_op();
        int pulses;
        do_clear();
        do_acc(W'(5), 1'b0);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (bus.busy !== 1'b1 || bus.result !== W'(5)) begin
            tests_failed++;
            $display("[TB] FAIL midreset_pre: got busy %0b result %0h expected 1/5", bus.busy, bus.result);
        end
        resetn = 1'b0;
        #1;
        tests_run++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== '0 || bus2.result !== '0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_now: got busy %0b done %0b result %0h/%0h expected 0/0/0/0", bus.busy, bus.done, bus.result, bus2.result);
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        pulses = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.done || bus2.done) pulses++;
        end
        tests_run++;
        if (pulses != 0 || bus.result !== '0 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_after: got pulses %0d result %0h busy %0b expected 0/0/0", pulses, bus.result, bus.busy);
        end
    endtask

    // Directed scenarios in sequence, then the one-line summary.
    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        resetn        = 1'b0;
        bus.clear     = 1'b0;
        bus.acc_en    = 1'b0;
        bus.acc_shift = 1'b0;
        bus.in_a      = '0;
        bus.in_m      = '0;
        bus.start     = 1'b0;
        bus.reduce    = 1'b0;
        test_reset();
        test_accumulate();
        test_shift();
        test_limb_boundary();
        test_reduce();
        test_protocol();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
